ltc2308_emu: RTL and testbench

LTC2308_EMU -- requirements
Module: ltc2308_emu

---
 rtl/ltc2308_emu_if.sv | 11 +
 rtl/ltc2308_emu.sv | 194 +++++++++++++++++++
 tb/tb_ltc2308_emu.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/ltc2308_emu_if.sv
// SPI-side pin bundle of the LTC2308 emulator: the master drives convst/sck/sdi
// and samples sdo.
interface ltc2308_emu_if;
    logic convst;
    logic sck;
    logic sdi;
    logic sdo;

    modport master (output convst, sck, sdi, input sdo);
    modport slave  (input convst, sck, sdi, output sdo);
endinterface

// File: rtl/ltc2308_emu.sv
// Behavioural LTC2308 stand-in: converts one of eight parallel input words on
// convst and shifts the result out on sck while collecting the next config word.
//
// state   | meaning
// IDLE    | waiting for the first convst rise after reset
// CONV    | conversion timer running, busy high
// READOUT | result on sdo, config bits collected on sck rise
// DONE    | frame complete, sdo parked low until next convst
module ltc2308_emu #(
    parameter int W           = 12,
    parameter int CONV_CYCLES = 80
) (
    input  logic               clk,
    input  logic               rst,
    ltc2308_emu_if.slave       spi,
    input  logic [8*W-1:0]     ch_data,
    output logic [5:0]         cfg,
    output logic               cfg_valid,
    output logic               busy,
    output logic               frame_done,
    output logic               err
);
    localparam int CCW = (CONV_CYCLES > 2) ? $clog2(CONV_CYCLES) : 1;
    localparam int DCW = $clog2(W + 1);
    localparam logic [CCW-1:0] CONV_LOAD = CCW'(CONV_CYCLES - 1);
    localparam logic [DCW-1:0] DATA_LAST = DCW'(W - 1);
    localparam logic [DCW-1:0] DATA_SAT  = DCW'(W);

    typedef enum logic [1:0] {IDLE, CONV, READOUT, DONE} state_t;
    state_t state, state_next;

    logic convst_s1, convst_s2, convst_d;
    logic sck_s1, sck_s2, sck_d;
    logic sdi_s1, sdi_s2;
    logic [2:0] fill;
    logic armed;
    logic convst_rise, sck_rise, sck_fall;

    logic [CCW-1:0] conv_cnt;
    logic [DCW-1:0] data_cnt;
    logic [2:0]     cfg_cnt;
    logic [5:0]     cfg_sr;
    logic           cfg_pend;
    logic [W-1:0]   res_sr;
    logic           sdo_q;

    logic start_conv, conv_end, cfg_shift, data_shift, frame_end, sck_err;
    logic [2:0]   ch_sel;
    logic [W-1:0] ch_raw, ch_latch;

    // A convst already high when reset lifts must be seen low once before
    // a rise counts; fill marks when the sync pipeline holds real samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            convst_s1 <= 1'b0;
            convst_s2 <= 1'b0;
            convst_d  <= 1'b0;
            sck_s1    <= 1'b0;
            sck_s2    <= 1'b0;
            sck_d     <= 1'b0;
            sdi_s1    <= 1'b0;
            sdi_s2    <= 1'b0;
            fill      <= '0;
            armed     <= 1'b0;
        end else begin
            convst_s1 <= spi.convst;
            convst_s2 <= convst_s1;
            convst_d  <= convst_s2;
            sck_s1    <= spi.sck;
            sck_s2    <= sck_s1;
            sck_d     <= sck_s2;
            sdi_s1    <= spi.sdi;
            sdi_s2    <= sdi_s1;
            fill      <= {fill[1:0], 1'b1};
            if (fill[2] && !convst_s2)
                armed <= 1'b1;
        end
    end

    assign convst_rise = armed & convst_s2 & ~convst_d;
    assign sck_rise    = sck_s2 & ~sck_d;
    assign sck_fall    = ~sck_s2 & sck_d;

    assign ch_sel   = {cfg[3], cfg[2], cfg[4]};
    assign ch_raw   = ch_data[ch_sel*W +: W];
    assign ch_latch = cfg[1] ? ch_raw : {~ch_raw[W-1], ch_raw[W-2:0]};

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        start_conv = 1'b0;
        conv_end   = 1'b0;
        cfg_shift  = 1'b0;
        data_shift = 1'b0;
        frame_end  = 1'b0;
        sck_err    = 1'b0;
        case (state)
            IDLE: begin
                if (convst_rise) begin
                    start_conv = 1'b1;
                    state_next = CONV;
                end
            end
            CONV: begin
                sck_err = sck_rise | sck_fall;
                if (conv_cnt == '0) begin
                    conv_end   = 1'b1;
                    state_next = READOUT;
                end
            end
            READOUT: begin
                if (convst_rise) begin
                    start_conv = 1'b1;
                    state_next = CONV;
                end else begin
                    cfg_shift = sck_rise && (cfg_cnt < 3'd6);
                    if (sck_fall) begin
                        data_shift = 1'b1;
                        if (data_cnt == DATA_LAST) begin
                            frame_end  = 1'b1;
                            state_next = DONE;
                        end
                    end
                end
            end
            DONE: begin
                if (convst_rise) begin
                    start_conv = 1'b1;
                    state_next = CONV;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conv_cnt   <= '0;
            data_cnt   <= '0;
            cfg_cnt    <= '0;
            cfg_sr     <= '0;
            cfg_pend   <= 1'b0;
            cfg        <= '0;
            cfg_valid  <= 1'b0;
            res_sr     <= '0;
            sdo_q      <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            frame_done <= frame_end;
            cfg_valid  <= cfg_pend;
            cfg_pend   <= cfg_shift && (cfg_cnt == 3'd5);
            // The commit uses the pre-edge cfg_sr, so a restart landing on
            // the same cycle cannot corrupt a word that was already complete.
            if (cfg_pend)
                cfg <= cfg_sr;
            if (sck_err)
                err <= 1'b1;

            if (start_conv) begin
                conv_cnt <= CONV_LOAD;
                res_sr   <= ch_latch;
                data_cnt <= '0;
                cfg_cnt  <= '0;
                cfg_sr   <= '0;
                sdo_q    <= 1'b0;
            end else begin
                if (state == CONV && conv_cnt != '0)
                    conv_cnt <= conv_cnt - 1'b1;
                if (conv_end)
                    sdo_q <= res_sr[W-1];
                if (cfg_shift) begin
                    cfg_sr  <= {cfg_sr[4:0], sdi_s2};
                    cfg_cnt <= cfg_cnt + 1'b1;
                end
                if (data_shift) begin
                    res_sr <= res_sr << 1;
                    sdo_q  <= frame_end ? 1'b0 : res_sr[W-2];
                    if (data_cnt != DATA_SAT)
                        data_cnt <= data_cnt + 1'b1;
                end
            end
        end
    end

    assign busy    = (state == CONV);
    assign spi.sdo = sdo_q;
endmodule

// File: tb/tb_ltc2308_emu.sv
// Directed bench for ltc2308_emu: drives SPI frames through the pin interface
// and compares read-back words and status against hand-computed values.
module tb_ltc2308_emu;
    localparam int W           = 12;
    localparam int CONV_CYCLES = 80;

    logic           clk = 1'b0;
    logic           rst;
    logic [8*W-1:0] ch_data;
    logic [5:0]     cfg;
    logic           cfg_valid, busy, frame_done, err;

    int n_chk = 0;
    int n_err = 0;
    int fd_cnt = 0;
    int cv_cnt = 0;
    int fd_mark, cv_mark;
    logic [W-1:0] rd;

    ltc2308_emu_if spi ();

    ltc2308_emu #(.W(W), .CONV_CYCLES(CONV_CYCLES)) dut (
        .clk        (clk),
        .rst        (rst),
        .spi        (spi),
        .ch_data    (ch_data),
        .cfg        (cfg),
        .cfg_valid  (cfg_valid),
        .busy       (busy),
        .frame_done (frame_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) fd_cnt++;
        if (cfg_valid)  cv_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_conv();
        spi.convst = 1'b1;
        wait_clk(5);
        spi.convst = 1'b0;
        wait_clk(CONV_CYCLES + 4);
    endtask

    // sdo is read just before each sck rise; the config word goes out MSB first.
    task automatic spi_xfer(input int nbits, input logic [5:0] cw, output logic [W-1:0] data);
        data = '0;
        for (int k = 0; k < nbits; k++) begin
            spi.sdi = (k < 6) ? cw[5-k] : 1'b0;
            wait_clk(2);
            data = {data[W-2:0], spi.sdo};
            spi.sck = 1'b1;
            wait_clk(5);
            spi.sck = 1'b0;
            wait_clk(5);
        end
        spi.sdi = 1'b0;
    endtask

    initial begin
        ch_data = {12'h777, 12'h666, 12'h555, 12'h7F0, 12'h333, 12'h222, 12'h123, 12'hA5C};
        spi.convst = 1'b0;
        spi.sck    = 1'b0;
        spi.sdi    = 1'b0;
        rst        = 1'b1;
        wait_clk(3);
        chk("rst_sdo",   {31'b0, spi.sdo},    32'd0);
        chk("rst_cfg",   {26'b0, cfg},        32'd0);
        chk("rst_busy",  {31'b0, busy},       32'd0);
        chk("rst_err",   {31'b0, err},        32'd0);
        chk("rst_fdone", {31'b0, frame_done}, 32'd0);
        rst = 1'b0;
        wait_clk(5);

        // Default cfg: ch0, bipolar -> MSB flipped
        fd_mark = fd_cnt;
        spi.convst = 1'b1;
        wait_clk(20);
        chk("busy_conv", {31'b0, busy}, 32'd1);
        spi.convst = 1'b0;
        wait_clk(CONV_CYCLES);
        chk("busy_end", {31'b0, busy}, 32'd0);
        spi_xfer(W, 6'b000000, rd);
        chk("f1_data", {20'b0, rd}, 32'h25C);
        chk("f1_fdone", fd_cnt - fd_mark, 32'd1);
        chk("f1_cfg", {26'b0, cfg}, 32'd0);
        chk("f1_sdo_done", {31'b0, spi.sdo}, 32'd0);

        // Extra sck after the frame: sdo stays low, no second frame_done
        fd_mark = fd_cnt;
        spi_xfer(2, 6'b000000, rd);
        chk("extra_sck_sdo", {20'b0, rd}, 32'd0);
        chk("extra_sck_sdo_now", {31'b0, spi.sdo}, 32'd0);
        chk("extra_sck_fdone", fd_cnt - fd_mark, 32'd0);

        // Send O/S=1, UNI=1; this frame still uses the old cfg
        cv_mark = cv_cnt;
        start_conv();
        spi_xfer(W, 6'b010010, rd);
        chk("f2_data", {20'b0, rd}, 32'h25C);
        chk("f2_cfg", {26'b0, cfg}, 32'h12);
        chk("f2_cfg_valid", cv_cnt - cv_mark, 32'd1);

        start_conv();
        spi_xfer(W, 6'b010010, rd);
        chk("f3_data_ch1", {20'b0, rd}, 32'h123);

        // sck during conversion flags err, readout still intact
        spi.convst = 1'b1;
        wait_clk(5);
        spi.convst = 1'b0;
        wait_clk(10);
        spi.sck = 1'b1;
        wait_clk(5);
        spi.sck = 1'b0;
        wait_clk(5);
        chk("err_set", {31'b0, err}, 32'd1);
        wait_clk(CONV_CYCLES);
        spi_xfer(W, 6'b010010, rd);
        chk("f4_data", {20'b0, rd}, 32'h123);
        chk("err_sticky", {31'b0, err}, 32'd1);

        // Abort after five falls: partial config dropped
        cv_mark = cv_cnt;
        start_conv();
        spi_xfer(5, 6'b000001, rd);
        chk("partial_bits", {20'b0, rd}, 32'h002);
        start_conv();
        chk("abort_cfg", {26'b0, cfg}, 32'h12);
        chk("abort_no_valid", cv_cnt - cv_mark, 32'd0);
        fd_mark = fd_cnt;
        spi_xfer(W, 6'b001000, rd);
        chk("f5_data", {20'b0, rd}, 32'h123);
        chk("f5_fdone", fd_cnt - fd_mark, 32'd1);
        chk("f5_cfg", {26'b0, cfg}, 32'h08);

        // cfg {S1=1} -> channel 4, bipolar
        start_conv();
        spi_xfer(W, 6'b001000, rd);
        chk("f6_data_ch4", {20'b0, rd}, 32'hFF0);

        // Reset in mid-conversion with convst held high across release
        spi.convst = 1'b1;
        wait_clk(20);
        chk("busy_pre_rst", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        wait_clk(1);
        chk("mrst_busy", {31'b0, busy},    32'd0);
        chk("mrst_err",  {31'b0, err},     32'd0);
        chk("mrst_cfg",  {26'b0, cfg},     32'd0);
        chk("mrst_sdo",  {31'b0, spi.sdo}, 32'd0);
        wait_clk(1);
        rst = 1'b0;
        fd_mark = fd_cnt;
        wait_clk(10);
        chk("held_convst_busy_a", {31'b0, busy}, 32'd0);
        wait_clk(90);
        chk("held_convst_busy_b", {31'b0, busy}, 32'd0);
        chk("held_convst_fdone", fd_cnt - fd_mark, 32'd0);
        spi.convst = 1'b0;
        wait_clk(5);
        start_conv();
        spi_xfer(W, 6'b000000, rd);
        chk("post_rst_data", {20'b0, rd}, 32'h25C);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
